// File: rtl/device_b_responder.sv
// Device-B side of a four-phase req/ack handshake: latches data on request,
// acknowledges after a fixed delay, counts transfers and flags protocol errors.
module device_b_responder #(
    parameter int unsigned DW        = 4,
    parameter int unsigned CW        = 8,
    parameter int unsigned ACK_DELAY = 3,
    parameter int unsigned TIMEOUT   = 200
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic [DW-1:0] data_in,
    output logic          ack,
    output logic [DW-1:0] data_out,
    output logic          data_valid,
    output logic [CW-1:0] xfer_count,
    output logic          busy,
    output logic          proto_err,
    output logic          timeout_err
);

    localparam int unsigned DCW = 8;
    localparam int unsigned TCW = 16;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_ACK  = 3'd2,
        S_REL  = 3'd3,
        S_ERR  = 3'd4
    } state_e;

    state_e         state_q;
    logic [DCW-1:0] dcnt_q;
    logic [TCW-1:0] tcnt_q;
    logic [DW-1:0]  data_q;
    logic [CW-1:0]  xfer_q;
    logic           ack_q;
    logic           dv_q;
    logic           busy_q;
    logic           proto_q;
    logic           tmo_q;

    // ack and busy are kept as explicit flops, set on the transition into the state they mirror
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            dcnt_q  <= '0;
            tcnt_q  <= '0;
            data_q  <= '0;
            xfer_q  <= '0;
            ack_q   <= 1'b0;
            dv_q    <= 1'b0;
            busy_q  <= 1'b0;
            proto_q <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            dv_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        data_q  <= data_in;
                        dcnt_q  <= '0;
                        state_q <= S_WAIT;
                        busy_q  <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (!req) begin
                        proto_q <= 1'b1;
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (dcnt_q == DCW'(ACK_DELAY - 1)) begin
                        state_q <= S_ACK;
                        ack_q   <= 1'b1;
                        dv_q    <= 1'b1;
                        tcnt_q  <= '0;
                    end else begin
                        dcnt_q <= dcnt_q + DCW'(1);
                    end
                end
                S_ACK: begin
                    // A falling req beats the timeout terminal count
                    if (!req) begin
                        state_q <= S_REL;
                        ack_q   <= 1'b0;
                        xfer_q  <= xfer_q + CW'(1);
                    end else if (tcnt_q == TCW'(TIMEOUT - 1)) begin
                        tmo_q   <= 1'b1;
                        state_q <= S_ERR;
                        ack_q   <= 1'b0;
                    end else begin
                        tcnt_q <= tcnt_q + TCW'(1);
                    end
                end
                S_REL: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                S_ERR: begin
                    if (!req) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    ack_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ack         = ack_q;
    assign data_out    = data_q;
    assign data_valid  = dv_q;
    assign xfer_count  = xfer_q;
    assign busy        = busy_q;
    assign proto_err   = proto_q;
    assign timeout_err = tmo_q;

endmodule

// File: tb/tb_device_b_responder.sv
// Directed bench for device_b_responder with ACK_DELAY=3, TIMEOUT=10.
module tb_device_b_responder;

    logic       clk;
    logic       reset;
    logic       req;
    logic [3:0] data_in;
    logic       ack;
    logic [3:0] data_out;
    logic       data_valid;
    logic [7:0] xfer_count;
    logic       busy;
    logic       proto_err;
    logic       timeout_err;

    int checks = 0;
    int errors = 0;

    device_b_responder #(
        .DW(4), .CW(8), .ACK_DELAY(3), .TIMEOUT(10)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .data_in(data_in),
        .ack(ack), .data_out(data_out), .data_valid(data_valid),
        .xfer_count(xfer_count), .busy(busy),
        .proto_err(proto_err), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        req = 1'b0;
        data_in = 4'h0;
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    // Normal transfer: ack after 3 edges, held `hold` cycles, then released
    task automatic do_xfer(input logic [3:0] d, input int hold);
        req = 1'b1;
        data_in = d;
        repeat (4) tick();
        repeat (hold) tick();
        req = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        req = 1'b0;
        data_in = 4'h0;
        reset = 1'b0;
        #3;
        tick();
        checks++;
        if ({ack, data_out, data_valid, xfer_count, busy, proto_err, timeout_err} !== 17'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {ack, data_out, data_valid, xfer_count, busy, proto_err, timeout_err});
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        req = 1'b1;
        data_in = 4'hA;
        tick();
        data_in = 4'h5;
        checks++;
        if (busy !== 1'b1 || ack !== 1'b0 || data_out !== 4'hA) begin
            errors++;
            $display("FAIL basic_capture: got busy=%b ack=%b data=%h expected 1 0 a", busy, ack, data_out);
        end
        tick();
        tick();
        checks++;
        if (ack !== 1'b0 || data_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_early_ack: got ack=%b dv=%b expected 0 0", ack, data_valid);
        end
        tick();
        checks++;
        if (ack !== 1'b1 || data_valid !== 1'b1 || data_out !== 4'hA) begin
            errors++;
            $display("FAIL basic_ack_rise: got ack=%b dv=%b data=%h expected 1 1 a", ack, data_valid, data_out);
        end
        tick();
        checks++;
        if (ack !== 1'b1 || data_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_dv_pulse: got ack=%b dv=%b expected 1 0", ack, data_valid);
        end
        req = 1'b0;
        tick();
        checks++;
        if (ack !== 1'b0 || xfer_count !== 8'd1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_release: got ack=%b cnt=%0d busy=%b expected 0 1 1", ack, xfer_count, busy);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || xfer_count !== 8'd1) begin
            errors++;
            $display("FAIL basic_idle: got busy=%b cnt=%0d expected 0 1", busy, xfer_count);
        end
    endtask

    task automatic test_proto_err();
        int saw_ack = 0;
        apply_reset();
        do_xfer(4'h1, 1);
        req = 1'b1;
        data_in = 4'h3;
        tick();
        if (ack) saw_ack++;
        tick();
        if (ack) saw_ack++;
        req = 1'b0;
        tick();
        if (ack) saw_ack++;
        checks++;
        if (saw_ack != 0 || proto_err !== 1'b1 || xfer_count !== 8'd1 || busy !== 1'b0 || data_out !== 4'h3) begin
            errors++;
            $display("FAIL proto_early_drop: got acks=%0d perr=%b cnt=%0d busy=%b data=%h expected 0 1 1 0 3",
                     saw_ack, proto_err, xfer_count, busy, data_out);
        end
        do_xfer(4'h7, 2);
        checks++;
        if (xfer_count !== 8'd2 || proto_err !== 1'b1 || data_out !== 4'h7) begin
            errors++;
            $display("FAIL proto_recover: got cnt=%0d perr=%b data=%h expected 2 1 7", xfer_count, proto_err, data_out);
        end
    endtask

    task automatic test_race_delay();
        int saw_ack = 0;
        apply_reset();
        req = 1'b1;
        data_in = 4'h9;
        repeat (3) begin
            tick();
            if (ack) saw_ack++;
        end
        req = 1'b0;
        tick();
        if (ack) saw_ack++;
        checks++;
        if (saw_ack != 0 || proto_err !== 1'b1 || busy !== 1'b0 || data_valid !== 1'b0) begin
            errors++;
            $display("FAIL race_delay: got acks=%0d perr=%b busy=%b dv=%b expected 0 1 0 0",
                     saw_ack, proto_err, busy, data_valid);
        end
    endtask

    task automatic test_timeout();
        int high = 0;
        apply_reset();
        req = 1'b1;
        data_in = 4'h2;
        repeat (4) tick();
        if (ack) high = 1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ack) high++;
            else break;
        end
        checks++;
        if (high != 10 || timeout_err !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_len: got high=%0d terr=%b busy=%b expected 10 1 1", high, timeout_err, busy);
        end
        repeat (5) tick();
        checks++;
        if (ack !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_hold: got ack=%b busy=%b expected 0 1", ack, busy);
        end
        req = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || xfer_count !== 8'd0 || timeout_err !== 1'b1 || data_valid !== 1'b0) begin
            errors++;
            $display("FAIL timeout_exit: got busy=%b cnt=%0d terr=%b dv=%b expected 0 0 1 0",
                     busy, xfer_count, timeout_err, data_valid);
        end
    endtask

    task automatic test_race_timeout();
        apply_reset();
        req = 1'b1;
        data_in = 4'h4;
        repeat (4) tick();
        repeat (9) tick();
        req = 1'b0;
        tick();
        checks++;
        if (ack !== 1'b0 || timeout_err !== 1'b0 || xfer_count !== 8'd1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL race_timeout: got ack=%b terr=%b cnt=%0d busy=%b expected 0 0 1 1",
                     ack, timeout_err, xfer_count, busy);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int ack_miss = 0;
        apply_reset();
        for (int i = 0; i < 256; i++) begin
            req = 1'b1;
            data_in = 4'(i);
            repeat (4) tick();
            if (ack !== 1'b1) ack_miss++;
            repeat (5) tick();
            req = 1'b0;
            tick();
            tick();
            if (i == 254) begin
                checks++;
                if (xfer_count !== 8'd255) begin
                    errors++;
                    $display("FAIL b2b_count_255: got %0d expected 255", xfer_count);
                end
            end
        end
        checks++;
        if (ack_miss != 0 || xfer_count !== 8'd0 || proto_err !== 1'b0 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL b2b_wrap: got miss=%0d cnt=%0d perr=%b terr=%b expected 0 0 0 0",
                     ack_miss, xfer_count, proto_err, timeout_err);
        end
    endtask

    task automatic test_reset_mid_ack();
        apply_reset();
        repeat (5) do_xfer(4'hC, 1);
        req = 1'b1;
        tick();
        req = 1'b0;
        tick();
        req = 1'b1;
        data_in = 4'hE;
        repeat (4) tick();
        checks++;
        if (ack !== 1'b1 || xfer_count !== 8'd5 || proto_err !== 1'b1) begin
            errors++;
            $display("FAIL rst_setup: got ack=%b cnt=%0d perr=%b expected 1 5 1", ack, xfer_count, proto_err);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (ack !== 1'b0 || xfer_count !== 8'd0 || proto_err !== 1'b0 || timeout_err !== 1'b0 ||
            data_out !== 4'h0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_async: got ack=%b cnt=%0d perr=%b terr=%b data=%h busy=%b expected all 0",
                     ack, xfer_count, proto_err, timeout_err, data_out, busy);
        end
        @(posedge clk);
        #1;
        data_in = 4'h6;
        reset = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b1 || data_out !== 4'h6 || ack !== 1'b0) begin
            errors++;
            $display("FAIL rst_restart: got busy=%b data=%h ack=%b expected 1 6 0", busy, data_out, ack);
        end
        req = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b0;
        req = 1'b0;
        data_in = 4'h0;
        test_reset();
        test_basic();
        test_proto_err();
        test_race_delay();
        test_timeout();
        test_race_timeout();
        test_back_to_back();
        test_reset_mid_ack();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
